// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of one shared combinational ALU.
//               It accepts one operation, executes it, and returns the result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_ALUFun,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic        req0_Sign,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_ALUFun,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic        req1_Sign,
    output logic [5:0]  alu_ALUFun,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic        alu_Sign,
    input  logic [31:0] alu_S,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_prio;
    logic        r_id;
    logic        r_rst_q;
    logic [5:0]  r_fun;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sign;
    logic [31:0] r_rsp_data;
    logic        w_gnt_en;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_rsp_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grants are also held off for the cycle following reset.
    always_comb begin
        w_gnt_en   = (r_state == S_IDLE) && !reset && !r_rst_q;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_rsp_take = r_id ? rsp1_ready : rsp0_ready;
        w_next     = r_state;
        if (w_gnt_en) begin
            if (req0_valid && req1_valid) begin
                if ((FIXED_PRI != 0) || !r_prio) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
        case (r_state)
            S_IDLE:  if (w_gnt0 || w_gnt1) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (w_rsp_take) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_rst_q <= reset;
        if (reset) begin
            r_prio     <= 1'b0;
            r_id       <= 1'b0;
            r_fun      <= 6'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_sign     <= 1'b0;
            r_rsp_data <= 32'd0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_id   <= w_gnt1;
                r_prio <= w_gnt0;
                r_fun  <= w_gnt1 ? req1_ALUFun : req0_ALUFun;
                r_a    <= w_gnt1 ? req1_A      : req0_A;
                r_b    <= w_gnt1 ? req1_B      : req0_B;
                r_sign <= w_gnt1 ? req1_Sign   : req0_Sign;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data <= alu_S;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = (r_state == S_RESP) && !r_id && !reset;
    assign rsp1_valid = (r_state == S_RESP) &&  r_id && !reset;
    assign rsp_data   = r_rsp_data;
    assign alu_ALUFun = r_fun;
    assign alu_A      = r_a;
    assign alu_B      = r_b;
    assign alu_Sign   = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter, round-robin and fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_Sign, req1_Sign;
    logic [5:0]  req0_ALUFun, req1_ALUFun;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic        rsp0_ready, rsp1_ready;

    logic        p0_req0_ready, p0_req1_ready, p0_rsp0_valid, p0_rsp1_valid, p0_alu_Sign;
    logic [5:0]  p0_alu_ALUFun;
    logic [31:0] p0_alu_A, p0_alu_B, p0_alu_S, p0_rsp_data;
    logic        p1_req0_ready, p1_req1_ready, p1_rsp0_valid, p1_rsp1_valid, p1_alu_Sign;
    logic [5:0]  p1_alu_ALUFun;
    logic [31:0] p1_alu_A, p1_alu_B, p1_alu_S, p1_rsp_data;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        id;
        logic [5:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    // Reference ALU: 0 = add, 1 = sub, anything else = xor.
    function automatic logic [31:0] alu_f(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'd0:    return a + b;
            6'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign p0_alu_S = alu_f(p0_alu_ALUFun, p0_alu_A, p0_alu_B);
    assign p1_alu_S = alu_f(p1_alu_ALUFun, p1_alu_A, p1_alu_B);

    alu_arbiter #(.FIXED_PRI(0)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(p0_req0_ready), .req0_ALUFun(req0_ALUFun),
        .req0_A(req0_A), .req0_B(req0_B), .req0_Sign(req0_Sign),
        .req1_valid(req1_valid), .req1_ready(p0_req1_ready), .req1_ALUFun(req1_ALUFun),
        .req1_A(req1_A), .req1_B(req1_B), .req1_Sign(req1_Sign),
        .alu_ALUFun(p0_alu_ALUFun), .alu_A(p0_alu_A), .alu_B(p0_alu_B), .alu_Sign(p0_alu_Sign),
        .alu_S(p0_alu_S),
        .rsp0_valid(p0_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(p0_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(p0_rsp_data)
    );

    alu_arbiter #(.FIXED_PRI(1)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(p1_req0_ready), .req0_ALUFun(req0_ALUFun),
        .req0_A(req0_A), .req0_B(req0_B), .req0_Sign(req0_Sign),
        .req1_valid(req1_valid), .req1_ready(p1_req1_ready), .req1_ALUFun(req1_ALUFun),
        .req1_A(req1_A), .req1_B(req1_B), .req1_Sign(req1_Sign),
        .alu_ALUFun(p1_alu_ALUFun), .alu_A(p1_alu_A), .alu_B(p1_alu_B), .alu_Sign(p1_alu_Sign),
        .alu_S(p1_alu_S),
        .rsp0_valid(p1_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(p1_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(p1_rsp_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic id, input logic [5:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        if (id) begin
            req1_valid = 1'b1; req1_ALUFun = fun; req1_A = a; req1_B = b; req1_Sign = 1'b1;
        end else begin
            req0_valid = 1'b1; req0_ALUFun = fun; req0_A = a; req0_B = b; req0_Sign = 1'b0;
        end
        #1;
        chk1("grant_own", id ? p0_req1_ready : p0_req0_ready, 1'b1);
        chk1("grant_other", id ? p0_req0_ready : p0_req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_A = 32'hDEADBEEF; req1_A = 32'hDEADBEEF; req0_B = 32'h0BADF00D; req1_B = 32'h0BADF00D;
        req0_ALUFun = 6'h3F; req1_ALUFun = 6'h3F; req0_Sign = ~id; req1_Sign = ~id;
        #1;
        chk("exec_alu_A", p0_alu_A, a);
        chk("exec_alu_B", p0_alu_B, b);
        chk("exec_fun", 32'(p0_alu_ALUFun), 32'(fun));
        chk1("exec_sign", p0_alu_Sign, id);
        chk("exec_no_rsp", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'd0);
        cyc();
        #1;
        chk1("resp_own_valid", id ? p0_rsp1_valid : p0_rsp0_valid, 1'b1);
        chk1("resp_other_valid", id ? p0_rsp0_valid : p0_rsp1_valid, 1'b0);
        chk("resp_data", p0_rsp_data, exp);
        chk("resp_data_fp", p1_rsp_data, exp);
        cyc();
        #1;
        chk("after_rsp_valid", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 6'd0,  32'd5,          32'd7,          32'd12};
        vt[1] = '{1'b1, 6'd1,  32'd10,         32'd3,          32'd7};
        vt[2] = '{1'b0, 6'h16, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFF00FF00};
        vt[3] = '{1'b1, 6'd0,  32'hFFFFFFFF,   32'd1,          32'd0};
        vt[4] = '{1'b0, 6'd1,  32'd0,          32'd1,          32'hFFFFFFFF};

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_ALUFun = 6'd5; req1_ALUFun = 6'd0; req0_Sign = 1'b1; req1_Sign = 1'b0;
        req0_A = 32'd1; req0_B = 32'd2; req1_A = 32'd3; req1_B = 32'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk1("rst_req0_ready", p0_req0_ready, 1'b0);
        chk1("rst_rsp0_valid", p0_rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", p0_rsp1_valid, 1'b0);
        chk("rst_alu_A", p0_alu_A, 32'd0);
        chk("rst_alu_B", p0_alu_B, 32'd0);
        chk("rst_alu_fun", 32'(p0_alu_ALUFun), 32'd0);
        chk1("rst_alu_sign", p0_alu_Sign, 1'b0);
        chk("rst_rsp_data", p0_rsp_data, 32'd0);

        // Contention straight out of reset: req0 computes 101, req1 computes 42.
        reset = 1'b0;
        req0_valid = 1'b1; req0_ALUFun = 6'd0; req0_A = 32'd100; req0_B = 32'd1;
        req1_valid = 1'b1; req1_ALUFun = 6'd1; req1_A = 32'd50;  req1_B = 32'd8;
        #1;
        chk("post_rst_ready_rr", 32'({p0_req1_ready, p0_req0_ready}), 32'd0);
        chk("post_rst_ready_fp", 32'({p1_req1_ready, p1_req0_ready}), 32'd0);
        for (int c = 0; c < 12; c++) begin
            logic g, id;
            cyc();
            #1;
            g  = ((c % 3) == 0);
            id = ((c / 3) % 2) == 1;
            chk("rr_grant", 32'({p0_req1_ready, p0_req0_ready}), 32'({g & id, g & ~id}));
            chk("fp_grant", 32'({p1_req1_ready, p1_req0_ready}), 32'({1'b0, g}));
            if ((c % 3) == 2) begin
                chk("rr_rsp_valid", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'({id, ~id}));
                chk("rr_rsp_data", p0_rsp_data, id ? 32'd42 : 32'd101);
                chk("fp_rsp_valid", 32'({p1_rsp1_valid, p1_rsp0_valid}), 32'd1);
                chk("fp_rsp_data", p1_rsp_data, 32'd101);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();

        for (int i = 0; i < 5; i++) begin
            do_op(vt[i].id, vt[i].fun, vt[i].a, vt[i].b, vt[i].exp);
        end

        // Backpressure on requester 1 while requester 0 waits.
        req1_valid = 1'b1; req1_ALUFun = 6'd0; req1_A = 32'd20; req1_B = 32'd22;
        cyc();
        req1_valid = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_ALUFun = 6'd0; req0_A = 32'd3; req0_B = 32'd4;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("bp_rsp1_valid", p0_rsp1_valid, 1'b1);
            chk("bp_rsp_data", p0_rsp_data, 32'd42);
            chk1("bp_no_grant", p0_req0_ready, 1'b0);
            cyc();
        end
        rsp1_ready = 1'b1;
        #1;
        chk1("bp_release_valid", p0_rsp1_valid, 1'b1);
        cyc();
        #1;
        chk1("bp_idle_rsp1", p0_rsp1_valid, 1'b0);
        chk1("bp_idle_grant0", p0_req0_ready, 1'b1);
        cyc();
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("wrong_cons_rsp0", p0_rsp0_valid, 1'b1);
            chk1("wrong_cons_rsp1", p0_rsp1_valid, 1'b0);
            chk("wrong_cons_data", p0_rsp_data, 32'd7);
            cyc();
        end
        rsp0_ready = 1'b1;
        cyc();
        #1;
        chk1("wrong_cons_done", p0_rsp0_valid, 1'b0);

        // Reset during EXEC; the following contended request must go to req0.
        req0_valid = 1'b1; req0_ALUFun = 6'd1; req0_A = 32'd9; req0_B = 32'd1;
        cyc();
        req0_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        req0_valid = 1'b1; req0_ALUFun = 6'd0; req0_A = 32'd1; req0_B = 32'd2;
        req1_valid = 1'b1; req1_ALUFun = 6'd1; req1_A = 32'd7; req1_B = 32'd7;
        #1;
        chk("midrst_rsp_valid", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'd0);
        chk("midrst_ready", 32'({p0_req1_ready, p0_req0_ready}), 32'd0);
        chk("midrst_alu_A", p0_alu_A, 32'd0);
        cyc();
        #1;
        chk("midrst_grant", 32'({p0_req1_ready, p0_req0_ready}), 32'd1);
        chk("midrst_no_rsp", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'd0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        #1;
        chk("midrst_rsp_valid2", 32'({p0_rsp1_valid, p0_rsp0_valid}), 32'd1);
        chk("midrst_rsp_data", p0_rsp_data, 32'd3);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRI, default 0, 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_ALUFun / req1_ALUFun  input  6  operation select, same encoding the ALU decodes.
REQ-007 req0_A, req0_B / req1_A, req1_B  input  32 each  operands.
REQ-008 req0_Sign / req1_Sign  input  1  signed-compare/overflow select.
REQ-009 alu_ALUFun  output  6; alu_A, alu_B  output  32 each; alu_Sign  output  1 -- drive the shared ALU.
REQ-010 alu_S  input  32  combinational ALU result.
REQ-011 rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-012 rsp0_ready / rsp1_ready  input  1  requester n consumes result.
REQ-013 rsp_data  output  32  result, shared by both response channels.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one operation outstanding at most.
REQ-015 req0_ready/req1_ready only asserted in IDLE, and at most one per cycle (one-hot or zero).
REQ-016 IDLE, exactly one valid: that requester granted (ready=1).
REQ-017 IDLE, both valid, FIXED_PRI=0: grant the requester indicated by priority pointer prio; FIXED_PRI=1: grant requester 0.
REQ-018 After each grant prio becomes the non-granted requester index; prio unchanged when no grant.
REQ-019 Handshake valid&ready in IDLE (cycle N): ALUFun, A, B, Sign and grant id latched into operand registers; FSM -> EXEC.
REQ-020 alu_* outputs driven from operand registers at all times (not combinationally from request inputs).
REQ-021 EXEC (cycle N+1): alu_S captured into rsp_data at end of cycle; FSM -> RESP.
REQ-022 RESP (cycle N+2 onward): rspK_valid=1 for granted id K only; other rsp valid 0.
REQ-023 rsp_data and rspK_valid held stable until rspK_ready=1; on that edge FSM -> IDLE, rspK_valid drops next cycle.
REQ-024 rsp_ready of the non-granted requester ignored.
REQ-025 Minimum issue-to-issue spacing 3 cycles (IDLE, EXEC, RESP with immediate ready); no grant in the cycle rsp is consumed.
REQ-026 Request inputs may change while not ready; arbiter never samples them outside IDLE grant cycle.
REQ-027 Requester dropping valid before grant: no operation, no state change.
REQ-028 Result bits passed unmodified; no width change, no sign handling in arbiter (ALU performs it via alu_Sign).

Reset
REQ-029 reset=1 at clock edge: FSM -> IDLE, prio -> 0, operand registers -> 0, rsp_data -> 0.
REQ-030 During reset and the cycle after: req*_ready=0, rsp*_valid=0, alu_ALUFun=0, alu_A=alu_B=0, alu_Sign=0.
REQ-031 Reset in EXEC or RESP aborts the operation; no response is ever issued for it.

Verification
REQ-032 Single request: req0 ALUFun=000000 (add), A=5, B=7, valid at cycle 1 -> req0_ready cycle 1, alu_A=5/alu_B=7 cycle 2, rsp0_valid=1 rsp_data=12 cycle 3, rsp1_valid=0.
REQ-033 Contention, FIXED_PRI=0: both valid continuously after reset -> grants alternate 0,1,0,1; each rsp_data matches its own operands.
REQ-034 Contention, FIXED_PRI=1: both valid continuously -> req0 granted every time, req1 never ready.
REQ-035 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp_data stable all 5, no new grant; release -> IDLE next cycle.
REQ-036 Reset mid-op: assert reset in EXEC -> next cycle all valid/ready low, no response; following request completes normally with prio=0.
REQ-037 Wrong consumer: in RESP for requester 0, rsp1_ready=1, rsp0_ready=0 -> state held in RESP, rsp0_valid stays 1.
